// File: rtl/conv_frame_loader.sv
// Switch-driven frame loader: synchronises the row/commit switches, builds a ROWS x COLS
// binary frame one row per strobe edge, and offers it downstream over valid/ready.
module conv_frame_loader #(
  parameter int unsigned ROWS        = 6,
  parameter int unsigned COLS        = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [COLS-1:0]            row_bits,
  input  logic                       row_strobe,
  input  logic                       commit,
  output logic [ROWS*COLS-1:0]       frame_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [$clog2(ROWS+1)-1:0]  rows_loaded,
  output logic                       overflow
);

  localparam int unsigned CntW = $clog2(ROWS + 1);

  typedef enum logic [1:0] {StFill, StFull, StValid} state_e;

  logic [COLS-1:0]        bits_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] strobe_sync_q, commit_sync_q;
  logic                   strobe_dly_q, commit_dly_q;
  logic                   strobe_s, commit_s;
  logic                   strobe_edge, commit_edge;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q;
  logic                   row_we;
  logic [ROWS*COLS-1:0]   frame_q;

  assign strobe_s = strobe_sync_q[SYNC_STAGES-1];
  assign commit_s = commit_sync_q[SYNC_STAGES-1];

  // Edge pulses are gated by ena; the synchronisers and delay flops keep running regardless.
  assign strobe_edge = ena & strobe_s & ~strobe_dly_q;
  assign commit_edge = ena & commit_s & ~commit_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) bits_sync_q[i] <= '0;
      strobe_sync_q <= '0;
      commit_sync_q <= '0;
      strobe_dly_q  <= 1'b0;
      commit_dly_q  <= 1'b0;
    end else begin
      bits_sync_q[0] <= row_bits;
      for (int i = 1; i < SYNC_STAGES; i++) bits_sync_q[i] <= bits_sync_q[i-1];
      strobe_sync_q <= {strobe_sync_q[SYNC_STAGES-2:0], row_strobe};
      commit_sync_q <= {commit_sync_q[SYNC_STAGES-2:0], commit};
      strobe_dly_q  <= strobe_s;
      commit_dly_q  <= commit_s;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    row_we  = 1'b0;
    case (state_q)
      StFill: begin
        if (strobe_edge) begin
          row_we = 1'b1;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntW'(ROWS - 1)) state_d = StFull;
        end
      end
      StFull: begin
        if (strobe_edge) ovf_d = 1'b1;
        if (commit_edge) state_d = StValid;
      end
      StValid: begin
        // Transfer clear takes priority over a coincident strobe edge.
        if (frame_ready) begin
          state_d = StFill;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (strobe_edge) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= (state_d == StValid);
      for (int r = 0; r < ROWS; r++) begin
        if (row_we && (cnt_q == CntW'(r))) frame_q[r*COLS +: COLS] <= bits_sync_q[SYNC_STAGES-1];
      end
    end
  end

  assign frame_data  = frame_q;
  assign frame_valid = valid_q;
  assign rows_loaded = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_conv_frame_loader.sv
// Self-checking bench for conv_frame_loader: table-driven frame loads with a transfer
// scoreboard, plus hand-written sequences for latency, overflow, disable and reset.
module tb_conv_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [5:0]  row_bits;
  logic        row_strobe;
  logic        commit;
  logic [35:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [2:0]  rows_loaded;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [35:0] exp_q [$];

  typedef struct packed {
    logic [5:0]  r0, r1, r2, r3, r4, r5;
    logic [35:0] exp_frame;
  } vec_t;

  vec_t vecs [4];

  conv_frame_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .row_bits    (row_bits),
    .row_strobe  (row_strobe),
    .commit      (commit),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .rows_loaded (rows_loaded),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle_row(input logic [5:0] bits);
    @(negedge clk);
    row_bits   = bits;
    row_strobe = 1'b1;
    cyc(4);
    row_strobe = 1'b0;
    cyc(4);
  endtask

  task automatic commit_pulse();
    @(negedge clk);
    commit = 1'b1;
    cyc(4);
    commit = 1'b0;
    cyc(4);
  endtask

  // Scoreboard: each completed transfer pops the oldest expected frame.
  always @(negedge clk) begin
    #2;
    if (rst_n && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_transfer", 64'(frame_data), 64'hDEAD);
      end else begin
        check("transfer_frame", 64'(frame_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    vecs[0] = '{r0:6'h01, r1:6'h02, r2:6'h04, r3:6'h08, r4:6'h10, r5:6'h20,
                exp_frame:36'h810204081};
    vecs[1] = '{r0:6'h3F, r1:6'h3F, r2:6'h3F, r3:6'h3F, r4:6'h3F, r5:6'h3F,
                exp_frame:36'hFFFFFFFFF};
    vecs[2] = '{r0:6'h2A, r1:6'h15, r2:6'h2A, r3:6'h15, r4:6'h2A, r5:6'h15,
                exp_frame:36'h56A56A56A};
    vecs[3] = '{r0:6'h00, r1:6'h3F, r2:6'h00, r3:6'h00, r4:6'h00, r5:6'h01,
                exp_frame:36'h040000FC0};

    rst_n       = 1'b0;
    ena         = 1'b1;
    row_bits    = '0;
    row_strobe  = 1'b0;
    commit      = 1'b0;
    frame_ready = 1'b0;
    cyc(3);
    check("reset_valid", 64'(frame_valid), 64'd0);
    check("reset_rows", 64'(rows_loaded), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_frame", 64'(frame_data), 64'd0);
    rst_n = 1'b1;
    cyc(2);

    for (int v = 0; v < 4; v++) begin
      toggle_row(vecs[v].r0);
      toggle_row(vecs[v].r1);
      toggle_row(vecs[v].r2);
      toggle_row(vecs[v].r3);
      toggle_row(vecs[v].r4);
      toggle_row(vecs[v].r5);
      check("tbl_rows_full", 64'(rows_loaded), 64'd6);
      check("tbl_valid_before_commit", 64'(frame_valid), 64'd0);
      exp_q.push_back(vecs[v].exp_frame);
      commit_pulse();
      check("tbl_valid_after_commit", 64'(frame_valid), 64'd1);
      frame_ready = 1'b1;
      @(negedge clk);
      check("tbl_valid_after_xfer", 64'(frame_valid), 64'd0);
      check("tbl_rows_after_xfer", 64'(rows_loaded), 64'd0);
      frame_ready = 1'b0;
      cyc(2);
    end

    // Latency: strobe sampled at edge k, write lands at edge k+2.
    @(negedge clk);
    row_bits   = 6'h2A;
    row_strobe = 1'b1;
    @(posedge clk); #1;
    check("lat_edge_k", 64'(rows_loaded), 64'd0);
    @(posedge clk); #1;
    check("lat_edge_k1_rows", 64'(rows_loaded), 64'd0);
    check("lat_edge_k1_data", 64'(frame_data[5:0]), 64'h00);
    @(posedge clk); #1;
    check("lat_edge_k2_rows", 64'(rows_loaded), 64'd1);
    check("lat_edge_k2_data", 64'(frame_data[5:0]), 64'h2A);
    @(negedge clk);
    row_strobe = 1'b0;
    cyc(4);

    // Overflow: seventh row in FULL.
    toggle_row(6'h01);
    toggle_row(6'h02);
    toggle_row(6'h03);
    toggle_row(6'h04);
    toggle_row(6'h05);
    check("ovf_before", 64'(overflow), 64'd0);
    toggle_row(6'h3F);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_rows", 64'(rows_loaded), 64'd6);
    check("ovf_frame_kept", 64'(frame_data), 64'h1440C206A);
    exp_q.push_back(36'h1440C206A);
    commit_pulse();
    check("ovf_valid", 64'(frame_valid), 64'd1);
    check("ovf_still_set", 64'(overflow), 64'd1);
    frame_ready = 1'b1;
    @(negedge clk);
    check("ovf_cleared", 64'(overflow), 64'd0);
    check("ovf_valid_dropped", 64'(frame_valid), 64'd0);
    frame_ready = 1'b0;
    cyc(2);

    // Early commit, disable, held strobe.
    toggle_row(6'h10);
    toggle_row(6'h20);
    toggle_row(6'h30);
    commit_pulse();
    check("early_commit_valid", 64'(frame_valid), 64'd0);
    check("early_commit_rows", 64'(rows_loaded), 64'd3);
    ena = 1'b0;
    toggle_row(6'h11);
    check("disabled_rows", 64'(rows_loaded), 64'd3);
    ena = 1'b1;
    cyc(2);
    @(negedge clk);
    row_bits   = 6'h22;
    row_strobe = 1'b1;
    cyc(10);
    row_strobe = 1'b0;
    cyc(4);
    check("held_strobe_rows", 64'(rows_loaded), 64'd4);

    // Simultaneous last-row strobe and commit: commit is ignored.
    toggle_row(6'h33);
    @(negedge clk);
    row_bits   = 6'h0C;
    row_strobe = 1'b1;
    commit     = 1'b1;
    cyc(4);
    row_strobe = 1'b0;
    commit     = 1'b0;
    cyc(4);
    check("simul_rows", 64'(rows_loaded), 64'd6);
    check("simul_valid", 64'(frame_valid), 64'd0);
    exp_q.push_back(36'h3338B0810);
    commit_pulse();
    check("simul_recommit_valid", 64'(frame_valid), 64'd1);
    frame_ready = 1'b1;
    @(negedge clk);
    check("simul_valid_dropped", 64'(frame_valid), 64'd0);
    frame_ready = 1'b0;
    cyc(2);

    // Reset while VALID, then a fresh load with ready held high.
    toggle_row(6'h01);
    toggle_row(6'h02);
    toggle_row(6'h03);
    toggle_row(6'h04);
    toggle_row(6'h05);
    toggle_row(6'h06);
    commit_pulse();
    check("pre_reset_valid", 64'(frame_valid), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(frame_valid), 64'd0);
    check("async_reset_rows", 64'(rows_loaded), 64'd0);
    check("async_reset_overflow", 64'(overflow), 64'd0);
    check("async_reset_frame", 64'(frame_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    frame_ready = 1'b1;
    toggle_row(6'h3F);
    toggle_row(6'h3E);
    toggle_row(6'h3D);
    toggle_row(6'h3C);
    toggle_row(6'h3B);
    toggle_row(6'h3A);
    check("post_reset_rows", 64'(rows_loaded), 64'd6);
    exp_q.push_back(36'hEBBF3DFBF);
    commit_pulse();
    check("post_reset_valid_done", 64'(frame_valid), 64'd0);
    check("post_reset_rows_done", 64'(rows_loaded), 64'd0);
    frame_ready = 1'b0;
    cyc(2);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
